// File: rtl/buffer_egress_drain.sv
// buffer_egress_drain
// Drains a first-word-fall-through FIFO onto a credit-controlled link.
// Packet framing is tracked from the head-flit length field so that head and
// tail flits are marked on the link. A credit stall mid-packet holds the state
// and the remaining-flit count, so the packet resumes without loss.

module buffer_egress_drain #(
   parameter int unsigned FLIT_W       = 64,
   parameter int unsigned LEN_LSB      = 56,
   parameter int unsigned LEN_W        = 4,
   parameter int unsigned CREDIT_W     = 4,
   parameter int unsigned INIT_CREDITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                fifo_empty,
   input  logic [FLIT_W-1:0]   fifo_data,
   output logic                fifo_consume,
   output logic                out_valid,
   output logic [FLIT_W-1:0]   out_data,
   output logic                out_head,
   output logic                out_tail,
   input  logic                credit_return,
   output logic [CREDIT_W-1:0] credits,
   output logic                busy,
   output logic [15:0]         pkt_count,
   output logic                err_credit_ovf
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_BODY = 1'b1;

   localparam logic [CREDIT_W-1:0] CRED_INIT = CREDIT_W'(INIT_CREDITS);
   localparam logic [CREDIT_W-1:0] CRED_ONE  = CREDIT_W'(1);
   localparam logic [LEN_W-1:0]    LEN_ONE   = LEN_W'(1);

   logic                state_q, state_d;
   logic [LEN_W-1:0]    remaining_q, remaining_d;
   logic [CREDIT_W-1:0] credits_q, credits_d;
   logic                err_q, err_d;
   logic [15:0]         pkt_count_q, pkt_count_d;
   logic                out_valid_q, out_valid_d;
   logic [FLIT_W-1:0]   out_data_q, out_data_d;
   logic                out_head_q, out_head_d;
   logic                out_tail_q, out_tail_d;

   logic                consume;
   logic                pkt_done;
   logic [LEN_W-1:0]    len_raw;
   logic [LEN_W-1:0]    len_eff;

   // Pop whenever a flit is present and the downstream has room for it.
   always_comb begin
      consume = ~rst & ~fifo_empty & (credits_q != '0);
   end

   // Head-flit length, a zero length field meaning a single-flit packet.
   always_comb begin
      len_raw = fifo_data[LEN_LSB +: LEN_W];
      len_eff = (len_raw == '0) ? LEN_ONE : len_raw;
   end

   // Packet framing: decide head/tail marking and next state for a popped flit.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      out_head_d  = 1'b0;
      out_tail_d  = 1'b0;
      pkt_done    = 1'b0;
      if (consume) begin
         if (state_q == ST_IDLE) begin
            out_head_d = 1'b1;
            if (len_eff == LEN_ONE) begin
               out_tail_d = 1'b1;
               pkt_done   = 1'b1;
            end else begin
               remaining_d = len_eff - LEN_ONE;
               state_d     = ST_BODY;
            end
         end else begin
            if (remaining_q == LEN_ONE) begin
               out_tail_d  = 1'b1;
               pkt_done    = 1'b1;
               remaining_d = '0;
               state_d     = ST_IDLE;
            end else begin
               remaining_d = remaining_q - LEN_ONE;
            end
         end
      end
   end

   // Credit accounting; a return with no free slot outstanding is flagged, not counted.
   always_comb begin
      credits_d = credits_q;
      err_d     = err_q;
      case ({consume, credit_return})
         2'b10: credits_d = credits_q - CRED_ONE;
         2'b01: begin
            if (credits_q == CRED_INIT) begin
               err_d = 1'b1;
            end else begin
               credits_d = credits_q + CRED_ONE;
            end
         end
         default: credits_d = credits_q;
      endcase
   end

   // Link output stage and packet counter next values.
   always_comb begin
      out_valid_d = consume;
      out_data_d  = consume ? fifo_data : out_data_q;
      pkt_count_d = pkt_count_q + {15'd0, pkt_done};
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         credits_q   <= CRED_INIT;
         err_q       <= 1'b0;
         pkt_count_q <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_head_q  <= 1'b0;
         out_tail_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         credits_q   <= credits_d;
         err_q       <= err_d;
         pkt_count_q <= pkt_count_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_head_q  <= out_head_d;
         out_tail_q  <= out_tail_d;
      end
   end

   // Output port mapping.
   always_comb begin
      fifo_consume   = consume;
      out_valid      = out_valid_q;
      out_data       = out_data_q;
      out_head       = out_head_q;
      out_tail       = out_tail_q;
      credits        = credits_q;
      busy           = (state_q == ST_BODY);
      pkt_count      = pkt_count_q;
      err_credit_ovf = err_q;
   end

endmodule
